// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_pkg
// Brief   : Shared NoC definitions: flit-type encoding, default flit width
//           and one-hot source-port encoding for the west output controller.
// Revision: 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int c_flit_w_default = 34;

  // Flit type carried in the two MSBs of every flit
  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // One-hot owner encoding of the sources that may feed the west output
  localparam int         c_num_src = 4;
  localparam logic [3:0] c_port_n  = 4'b0001;
  localparam logic [3:0] c_port_s  = 4'b0010;
  localparam logic [3:0] c_port_e  = 4'b0100;
  localparam logic [3:0] c_port_l  = 4'b1000;

  // Tail and single flits both close the packet
  function automatic logic is_last(flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/w_output_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : w_output_ctrl_if
// Brief   : West link bundle: registered flit/valid toward the neighbour and
//           the credit-return pulse coming back from its input buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface w_output_ctrl_if #(
  parameter int FLIT_W = noc_pkg::c_flit_w_default
);
  logic [FLIT_W-1:0] w_flit_o;
  logic              w_valid_o;
  logic              w_credit_i;

  modport master (output w_flit_o, output w_valid_o, input w_credit_i);
  modport slave  (input w_flit_o, input w_valid_o, output w_credit_i);
endinterface
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module  : credit_counter
// Brief   : Tracks free slots in the downstream buffer, 0..BUF_DEPTH.
//           A credit arriving while already full is dropped and flagged.
// Revision: 1.0 - initial release
// ============================================================================
module credit_counter #(
  parameter  int BUF_DEPTH = 4,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             dec,
  output logic [CNT_W-1:0]      count,
  output logic                  nonzero,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: simultaneous inc/dec cancel; a full-counter credit is dropped
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (inc && !dec) begin
      if (count_q == c_full) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, reloaded to a full buffer on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= c_full;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign nonzero = |count_q;

endmodule
`default_nettype wire

// File: rtl/w_output_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : w_output_ctrl
// Brief   : West output-port controller. Accepts a one-hot grant, then
//           forwards the owner's flits to the west link under credit flow
//           control until a tail/single flit releases the port.
// Revision: 1.0 - initial release
// ============================================================================
module w_output_ctrl
  import noc_pkg::*;
#(
  parameter  int FLIT_W    = c_flit_w_default,
  parameter  int BUF_DEPTH = 4,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              rrp_w_priority_to_cs_i,
  input  wire logic              rrp_w_priority_n_i,
  input  wire logic              rrp_w_priority_s_i,
  input  wire logic              rrp_w_priority_w_i,
  input  wire logic              rrp_w_priority_e_i,
  input  wire logic              rrp_w_priority_l_i,
  input  wire logic [FLIT_W-1:0] n_flit_i,
  input  wire logic [FLIT_W-1:0] s_flit_i,
  input  wire logic [FLIT_W-1:0] e_flit_i,
  input  wire logic [FLIT_W-1:0] l_flit_i,
  input  wire logic              n_valid_i,
  input  wire logic              s_valid_i,
  input  wire logic              e_valid_i,
  input  wire logic              l_valid_i,
  output logic                   n_pop_o,
  output logic                   s_pop_o,
  output logic                   e_pop_o,
  output logic                   l_pop_o,
  w_output_ctrl_if.master        w_link,
  output logic                   rr_register_change_order_o,
  output logic                   w_busy_o,
  output logic                   w_err_o,
  output logic [CNT_W-1:0]       w_credits_o
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_busy = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        owner_q, owner_d;
  logic [FLIT_W-1:0] w_flit_q, w_flit_d;
  logic              w_valid_q, w_valid_d;
  logic              chg_q, chg_d;
  logic              err_q, err_d;

  logic [3:0]        grant;
  logic [3:0]        src_valid;
  logic [FLIT_W-1:0] src_flit [c_num_src];
  logic [FLIT_W-1:0] sel_flit;
  logic              sel_valid;
  logic              sel_last;
  logic              legal;
  logic              pop;
  logic              cred_nonzero;
  logic              cred_overflow;

  assign grant       = {rrp_w_priority_l_i, rrp_w_priority_e_i,
                        rrp_w_priority_s_i, rrp_w_priority_n_i};
  assign src_valid   = {l_valid_i, e_valid_i, s_valid_i, n_valid_i};
  assign src_flit[0] = n_flit_i;
  assign src_flit[1] = s_flit_i;
  assign src_flit[2] = e_flit_i;
  assign src_flit[3] = l_flit_i;

  // Exactly one of n/s/e/l and never a west-to-west turn
  assign legal = rrp_w_priority_to_cs_i && $onehot(grant) && !rrp_w_priority_w_i;

  // One-hot AND-OR source mux steered by the latched owner
  always_comb begin
    sel_flit  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < c_num_src; i++) begin
      if (owner_q[i]) begin
        sel_flit  = sel_flit | src_flit[i];
        sel_valid = sel_valid | src_valid[i];
      end
    end
  end

  assign sel_last = is_last(flit_type_e'(sel_flit[FLIT_W-1:FLIT_W-2]));

  // Pop is suppressed while reset is held so no buffer is drained
  assign pop     = reset && (state_q == c_busy) && sel_valid && cred_nonzero;
  assign n_pop_o = pop && owner_q[0];
  assign s_pop_o = pop && owner_q[1];
  assign e_pop_o = pop && owner_q[2];
  assign l_pop_o = pop && owner_q[3];

  // FSM, output register and sticky-error next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    w_flit_d  = pop ? sel_flit : w_flit_q;
    w_valid_d = pop;
    chg_d     = pop && sel_last;
    err_d     = err_q || cred_overflow;
    case (state_q)
      c_idle: begin
        if (rrp_w_priority_to_cs_i) begin
          if (legal) begin
            state_d = c_busy;
            owner_d = grant;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      c_busy: begin
        if (pop && sel_last) begin
          state_d = c_idle;
          owner_d = '0;
        end
      end
      default: begin
        state_d = c_idle;
        owner_d = '0;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= c_idle;
      owner_q   <= '0;
      w_flit_q  <= '0;
      w_valid_q <= 1'b0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      w_flit_q  <= w_flit_d;
      w_valid_q <= w_valid_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
    end
  end

  credit_counter #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_credit_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_link.w_credit_i),
    .dec      (pop),
    .count    (w_credits_o),
    .nonzero  (cred_nonzero),
    .overflow (cred_overflow)
  );

  assign w_link.w_flit_o         = w_flit_q;
  assign w_link.w_valid_o        = w_valid_q;
  assign rr_register_change_order_o = chg_q;
  assign w_busy_o                = (state_q == c_busy);
  assign w_err_o                 = err_q;

endmodule
`default_nettype wire

// File: doc/w_output_ctrl.md
W_OUTPUT_CTRL -- requirements
Module: w_output_ctrl

Interface
REQ-001 Parameter FLIT_W, default 34: flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type.
REQ-002 Parameter BUF_DEPTH, default 4: downstream west input buffer depth, which is also the initial credit count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 rrp_w_priority_to_cs_i  input  1  grant-valid from the west round-robin processor.
REQ-006 rrp_w_priority_{n,s,w,e,l}_i  input  1 each  one-hot grant per source port.
REQ-007 {n,s,e,l}_flit_i  input  FLIT_W each  head-of-queue flit of each input buffer.
REQ-008 {n,s,e,l}_valid_i  input  1 each  head-of-queue flit valid.
REQ-009 {n,s,e,l}_pop_o  output  1 each  combinational dequeue strobe to each input buffer.
REQ-010 w_flit_o  output  FLIT_W  registered flit toward the west link.
REQ-011 w_valid_o  output  1  registered; w_flit_o is valid this cycle.
REQ-012 w_credit_i  input  1  one-cycle pulse; the downstream buffer freed one slot.
REQ-013 rr_register_change_order_o  output  1  one-cycle pulse that rotates the round-robin registers.
REQ-014 w_busy_o  output  1  high while a packet owns the port.
REQ-015 w_err_o  output  1  sticky illegal-grant flag.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY.
REQ-017 In IDLE, a grant is legal when to_cs_i=1 and exactly one of n/s/e/l is high with w low; a legal grant SHALL latch the owner and move to BUSY on the next edge.
REQ-018 In IDLE, to_cs_i=1 with zero, multiple, or w-only grant bits SHALL leave the FSM in IDLE and set w_err_o.
REQ-019 In BUSY, grant inputs SHALL be ignored.
REQ-020 The owner's pop_o SHALL equal BUSY & owner_valid_i & (credits>0); all other pop_o SHALL be 0.
REQ-021 The pop_o of a non-owner port SHALL never be 1.
REQ-022 On a pop, the next edge SHALL load w_flit_o with the owner flit and assert w_valid_o for one cycle, giving 1-cycle pop-to-output latency.
REQ-023 When no pop occurs, w_valid_o SHALL be 0 and w_flit_o SHALL hold its value.
REQ-024 Flit type encoding: 00 head, 01 body, 10 tail, 11 single.
REQ-025 A popped tail or single flit SHALL assert rr_register_change_order_o in the same cycle as its w_valid_o and return the FSM to IDLE.
REQ-026 A new grant SHALL be accepted in the same cycle that rr_register_change_order_o is high.
REQ-027 Flit types SHALL NOT be checked otherwise; a head arriving mid-packet is forwarded unchanged.
REQ-028 The credit counter SHALL range 0..BUF_DEPTH: it decrements on pop and increments on w_credit_i.
REQ-029 A simultaneous pop and credit SHALL leave the count unchanged.
REQ-030 A credit arriving at BUF_DEPTH SHALL be ignored and SHALL set w_err_o.
REQ-031 At 0 credits, no pop SHALL occur.
REQ-032 w_busy_o SHALL equal (state==BUSY).

Reset
REQ-033 While reset=0 at an edge: state IDLE, owner cleared, credits=BUF_DEPTH, w_flit_o=0, w_valid_o=0, change_order=0, w_err_o=0.
REQ-034 All pop_o SHALL be 0 during reset.
REQ-035 A reset mid-packet SHALL abandon the packet without emitting a change_order pulse.

Structure
REQ-036 A shared package noc_pkg SHALL hold the flit-type enum, the FLIT_W default, and the one-hot port encoding constants.
REQ-037 The credit counter SHALL be a separate sub-module, credit_counter (parameter BUF_DEPTH; inputs inc, dec; outputs count, nonzero, overflow).
REQ-038 The source flit mux SHALL be one-hot, selected by the latched owner.

Verification
REQ-039 Reset, then a legal grant from e, then e sends single flit 0x3_0000_00AA -> w_flit_o=0x3_0000_00AA one cycle after e_pop_o, change_order pulses once, FSM returns to IDLE, credits=3.
REQ-040 Grant n, then a 4-flit packet (head, body, body, tail) with n_valid_i=1 every cycle -> four consecutive w_valid_o, exactly one change_order on the tail, credits 4->0.
REQ-041 Grant l, 6-flit packet, no credits returned -> exactly 4 pops, then stall with l_pop_o=0; one w_credit_i pulse -> exactly one more pop.
REQ-042 Grant with n and s both high, then a w-only grant -> FSM stays IDLE, w_err_o=1 and stays 1 until reset.
REQ-043 Reset asserted after 2 flits of a 4-flit packet -> after reset, w_busy_o=0, credits=4, no change_order pulse.
REQ-044 Pop and w_credit_i in the same cycle at credits=2 -> credits remain 2; w_credit_i at credits=4 -> w_err_o=1 and credits remain 4.
